// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode constants and
// the parity helper (also intended for a future uart_tx_fifo).
//   rx_state_t         receiver FSM states
//   PARITY_NONE/ODD/EVEN  parity mode selector values
//   parity_bit()       parity bit a transmitter would append to a payload
package uart_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_ODD    = 1;
    localparam int PARITY_EVEN   = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Payload must be zero-extended to MAX_DATA_BITS; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational (registered-read-free) head output.
//   clk, rst   clock, synchronous active-low reset
//   push/wdata write request; ignored when full unless a pop happens the same cycle
//   pop        read request; ignored when empty (no bypass of a same-cycle push)
//   rdata      head entry, forced to 0 while empty
//   full/empty/count  occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a word FIFO behind a valid/ready port.
//   clk, rst     clock, synchronous active-low reset
//   rx           asynchronous serial input, idle high
//   m_data/m_perr/m_ferr  head-of-FIFO payload and error tags
//   m_valid/m_ready       stream handshake; pop when both high
//   overrun      one-cycle pulse when a completed frame is dropped (FIFO full)
//   fifo_count   entries held
//
// state  | meaning
// IDLE   | line idle; waits for start edge (or for line high after a break)
// START  | confirming start bit at its centre
// DATA   | sampling payload bits, LSB first
// PARITY | sampling and checking the parity bit
// STOP   | sampling stop bit(s); pushes the word on the last one
module uart_rx_fifo #(
    parameter int CLKS_PER_SAMPLE = 325,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    import uart_pkg::*;

    localparam int TW = $clog2(CLKS_PER_SAMPLE + 1);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int EW = DATA_BITS + 2;

    localparam logic [TW-1:0] TICK_RELOAD = TW'(CLKS_PER_SAMPLE - 1);
    localparam logic [SW-1:0] SC_MID      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_LAST     = SW'(OVERSAMPLE - 1);

    logic                 rx_m;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    rx_state_t            state;
    logic [SW-1:0]        sc;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic [MAX_DATA_BITS-1:0] shift_ext;
    logic                 perr;
    logic                 ferr;
    logic                 wait_high;
    logic                 start_seen;
    logic                 push;
    logic                 full;
    logic                 empty;
    logic [EW-1:0]        wdata;
    logic [EW-1:0]        rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign start_seen = (state == IDLE) && !wait_high && !rx_s;
    assign tick       = (tick_cnt == '0);
    assign shift_ext  = MAX_DATA_BITS'(shift);

    // Down-counter; reloading on the start edge puts every bit sample
    // a whole number of ticks after that edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= TICK_RELOAD;
        end else if (start_seen || tick) begin
            tick_cnt <= TICK_RELOAD;
        end else begin
            tick_cnt <= tick_cnt - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sc        <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            wait_high <= 1'b0;
        end else if (state == IDLE) begin
            if (wait_high) begin
                if (rx_s) wait_high <= 1'b0;
            end else if (!rx_s) begin
                state <= START;
                sc    <= '0;
                perr  <= 1'b0;
                ferr  <= 1'b0;
            end
        end else if (tick) begin
            case (state)
                START: begin
                    if (sc == SC_MID) begin
                        sc      <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        sc <= sc + SW'(1);
                    end
                end
                DATA: begin
                    if (sc == SC_LAST) begin
                        sc    <= '0;
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        sc <= sc + SW'(1);
                    end
                end
                uart_pkg::PARITY: begin
                    if (sc == SC_LAST) begin
                        sc       <= '0;
                        perr     <= (rx_s != parity_bit(shift_ext, PARITY));
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end else begin
                        sc <= sc + SW'(1);
                    end
                end
                STOP: begin
                    if (sc == SC_LAST) begin
                        sc <= '0;
                        if (!rx_s) ferr <= 1'b1;
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            state <= IDLE;
                            // Last stop sample low: a break; do not re-arm until the line returns high.
                            wait_high <= !rx_s;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        sc <= sc + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push  = tick && (state == STOP) && (sc == SC_LAST) && (stop_idx == 1'(STOP_BITS - 1));
    // The last stop sample is folded in directly since ferr only updates next cycle.
    assign wdata = {perr, ferr | ~rx_s, shift};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (m_ready),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign m_valid = !empty;
    assign m_perr  = rdata[EW-1];
    assign m_ferr  = rdata[EW-2];
    assign m_data  = rdata[DATA_BITS-1:0];
    assign overrun = push && full && !m_ready;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int CPS      = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = CPS * OS;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // 8N1 instance
    logic       rx_n = 1'b1;
    logic       ready_n = 1'b0;
    logic [7:0] data_n;
    logic       perr_n, ferr_n, valid_n, ovr_n;
    logic [3:0] count_n;
    // 8E1 instance
    logic       rx_e = 1'b1;
    logic       ready_e = 1'b0;
    logic [7:0] data_e;
    logic       perr_e, ferr_e, valid_e, ovr_e;
    logic [3:0] count_e;
    // 7O2 instance
    logic       rx_o = 1'b1;
    logic       ready_o = 1'b0;
    logic [6:0] data_o;
    logic       perr_o, ferr_o, valid_o, ovr_o;
    logic [3:0] count_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] q_n[$];
    logic [10:0] q_e[$];
    logic [10:0] q_o[$];
    int vcyc_n = 0;
    int ovr_cnt_n = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_SAMPLE(CPS), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) dut_n (
        .clk(clk), .rst(rst), .rx(rx_n), .m_data(data_n), .m_perr(perr_n), .m_ferr(ferr_n),
        .m_valid(valid_n), .m_ready(ready_n), .overrun(ovr_n), .fifo_count(count_n));

    uart_rx_fifo #(.CLKS_PER_SAMPLE(CPS), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) dut_e (
        .clk(clk), .rst(rst), .rx(rx_e), .m_data(data_e), .m_perr(perr_e), .m_ferr(ferr_e),
        .m_valid(valid_e), .m_ready(ready_e), .overrun(ovr_e), .fifo_count(count_e));

    uart_rx_fifo #(.CLKS_PER_SAMPLE(CPS), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(8)) dut_o (
        .clk(clk), .rst(rst), .rx(rx_o), .m_data(data_o), .m_perr(perr_o), .m_ferr(ferr_o),
        .m_valid(valid_o), .m_ready(ready_o), .overrun(ovr_o), .fifo_count(count_o));

    // Pop monitor: the values seen at negedge are those the next posedge acts on.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_n && ready_n) q_n.push_back({perr_n, ferr_n, 1'b0, data_n});
            if (valid_e && ready_e) q_e.push_back({perr_e, ferr_e, 1'b0, data_e});
            if (valid_o && ready_o) q_o.push_back({perr_o, ferr_o, 2'b00, data_o});
            if (valid_n) vcyc_n++;
            if (ovr_n) ovr_cnt_n++;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        case (which)
            0:       rx_n = v;
            1:       rx_e = v;
            default: rx_o = v;
        endcase
    endtask

    // bits[0] is sent first (start bit)
    task automatic send_bits(input int which, input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(which, bits[i]);
            wait_clks(BIT_CLKS);
        end
        set_rx(which, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        wait_clks(5);
        n_cmp++; if (valid_n !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_n); end
        n_cmp++; if (count_n !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_n); end
        n_cmp++; if (ovr_n !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", ovr_n); end
        n_cmp++; if ({perr_n, ferr_n, data_n} !== 10'h000) begin n_err++;
            $display("FAIL reset_head got %h want 000", {perr_n, ferr_n, data_n}); end
        n_cmp++; if ({valid_e, valid_o} !== 2'b00) begin n_err++; $display("FAIL reset_valid_eo got %b want 00", {valid_e, valid_o}); end
        rst = 1'b1;
        wait_clks(5);
    endtask

    task automatic test_8n1;
        int base = q_n.size();
        int v0 = vcyc_n;
        ready_n = 1'b1;
        send_bits(0, {1'b1, 1'b1, 8'hA5, 1'b0}, 10);
        wait_clks(BIT_CLKS);
        n_cmp++; if (q_n.size() - base !== 1) begin n_err++; $display("FAIL 8n1_pops got %0d want 1", q_n.size() - base); end
        if (q_n.size() > base) begin
            n_cmp++; if (q_n[base] !== 11'h0A5) begin n_err++; $display("FAIL 8n1_word got %h want 0a5", q_n[base]); end
        end
        n_cmp++; if (vcyc_n - v0 !== 1) begin n_err++; $display("FAIL 8n1_valid_cycles got %0d want 1", vcyc_n - v0); end
        n_cmp++; if (count_n !== 4'd0) begin n_err++; $display("FAIL 8n1_count got %0d want 0", count_n); end
    endtask

    task automatic test_parity;
        int base = q_e.size();
        ready_e = 1'b1;
        send_bits(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);   // parity 0 is wrong for even
        send_bits(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);   // correct even parity
        wait_clks(BIT_CLKS);
        n_cmp++; if (q_e.size() - base !== 2) begin n_err++; $display("FAIL par_pops got %0d want 2", q_e.size() - base); end
        if (q_e.size() >= base + 2) begin
            n_cmp++; if (q_e[base] !== 11'h407) begin n_err++; $display("FAIL par_bad got %h want 407", q_e[base]); end
            n_cmp++; if (q_e[base+1] !== 11'h007) begin n_err++; $display("FAIL par_good got %h want 007", q_e[base+1]); end
        end
    endtask

    task automatic test_framing;
        int base = q_n.size();
        ready_n = 1'b1;
        send_bits(0, {1'b0, 1'b0, 8'h3C, 1'b0}, 10);
        set_rx(0, 1'b0);                    // hold break for 3 frame times
        wait_clks(3 * 10 * BIT_CLKS);
        set_rx(0, 1'b1);
        wait_clks(2 * BIT_CLKS);
        n_cmp++; if (q_n.size() - base !== 1) begin n_err++; $display("FAIL brk_pops got %0d want 1", q_n.size() - base); end
        if (q_n.size() > base) begin
            n_cmp++; if (q_n[base] !== 11'h23C) begin n_err++; $display("FAIL brk_word got %h want 23c", q_n[base]); end
        end
    endtask

    task automatic test_glitch;
        ready_n = 1'b0;
        set_rx(0, 1'b0);
        wait_clks(3 * CPS);
        set_rx(0, 1'b1);
        wait_clks(12 * BIT_CLKS);
        n_cmp++; if (count_n !== 4'd0) begin n_err++; $display("FAIL glitch_count got %0d want 0", count_n); end
        n_cmp++; if (valid_n !== 1'b0) begin n_err++; $display("FAIL glitch_valid got %b want 0", valid_n); end
    endtask

    task automatic test_overrun;
        int base;
        int o0 = ovr_cnt_n;
        logic [10:0] exp;
        ready_n = 1'b0;
        for (int i = 0; i < 8; i++) send_bits(0, {1'b1, 1'b1, 8'(i), 1'b0}, 10);
        wait_clks(20);
        n_cmp++; if (count_n !== 4'd8) begin n_err++; $display("FAIL ovr_count8 got %0d want 8", count_n); end
        n_cmp++; if (ovr_cnt_n - o0 !== 0) begin n_err++; $display("FAIL ovr_early got %0d want 0", ovr_cnt_n - o0); end
        send_bits(0, {1'b1, 1'b1, 8'h08, 1'b0}, 10);
        wait_clks(20);
        n_cmp++; if (ovr_cnt_n - o0 !== 1) begin n_err++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt_n - o0); end
        n_cmp++; if (count_n !== 4'd8) begin n_err++; $display("FAIL ovr_count9 got %0d want 8", count_n); end
        n_cmp++; if (data_n !== 8'h00) begin n_err++; $display("FAIL ovr_head got %h want 00", data_n); end
        base = q_n.size();
        ready_n = 1'b1;
        wait_clks(20);
        n_cmp++; if (q_n.size() - base !== 8) begin n_err++; $display("FAIL drain_pops got %0d want 8", q_n.size() - base); end
        for (int i = 0; i < 8; i++) begin
            if (q_n.size() > base + i) begin
                exp = {3'b000, 8'(i)};
                n_cmp++; if (q_n[base+i] !== exp) begin n_err++;
                    $display("FAIL drain_word%0d got %h want %h", i, q_n[base+i], exp); end
            end
        end
        n_cmp++; if (count_n !== 4'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", count_n); end
    endtask

    task automatic test_reset_midframe;
        int base = q_n.size();
        ready_n = 1'b1;
        send_bits(0, {6'b111111, 4'hF, 1'b0}, 5);   // start + data bits 0..3 of 0xFF
        set_rx(0, 1'b1);
        wait_clks(BIT_CLKS / 2);                     // middle of bit 4
        rst = 1'b0;
        wait_clks(4);
        n_cmp++; if (count_n !== 4'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", count_n); end
        rst = 1'b1;
        wait_clks(12 * BIT_CLKS);
        send_bits(0, {1'b1, 1'b1, 8'h12, 1'b0}, 10);
        wait_clks(BIT_CLKS);
        n_cmp++; if (q_n.size() - base !== 1) begin n_err++; $display("FAIL mid_pops got %0d want 1", q_n.size() - base); end
        if (q_n.size() > base) begin
            n_cmp++; if (q_n[base] !== 11'h012) begin n_err++; $display("FAIL mid_word got %h want 012", q_n[base]); end
        end
    endtask

    task automatic test_7o2;
        int base = q_o.size();
        ready_o = 1'b1;
        send_bits(2, {1'b1, 1'b1, 1'b1, 7'h55, 1'b0}, 11);   // four ones -> odd parity bit 1
        send_bits(2, {1'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 11);   // second stop bit low
        wait_clks(2 * BIT_CLKS);
        n_cmp++; if (q_o.size() - base !== 2) begin n_err++; $display("FAIL 7o2_pops got %0d want 2", q_o.size() - base); end
        if (q_o.size() >= base + 2) begin
            n_cmp++; if (q_o[base] !== 11'h055) begin n_err++; $display("FAIL 7o2_word got %h want 055", q_o[base]); end
            n_cmp++; if (q_o[base+1] !== 11'h255) begin n_err++; $display("FAIL 7o2_stop2 got %h want 255", q_o[base+1]); end
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_framing;
        test_glitch;
        test_overrun;
        test_reset_midframe;
        test_7o2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
